jump_redirect_unit: RTL and testbench
=====================================

# jump_redirect_unit

Registered jump-resolution unit for the EX stage of the pipelined MIPS CPU. It computes the jump target for J, JAL and JR and holds it as a redirect request to the fetch stage with a valid/ready handshake. It stalls EX while a redirect is pending. A parametrised return-address stack (RAS) is pushed on JAL and popped on JR $ra, giving fetch an early return-target prediction.

## Interface
- XLEN, 32, datapath/PC width (>= 32)
- RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)
- CNT_W, 16, width of the redirect event counter

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX stage holds a valid instruction this cycle
- ex_jump_mode  in  2  00 none, 01 J, 10 JR, 11 JAL
- ex_pc_plus4  in  XLEN  PC+4 of the EX instruction
- ex_instr  in  32  EX instruction word (bits [25:0] = jump index)
- ex_rs_data  in  XLEN  forwarded GPR[rs] value
- ex_rs_is_ra  in  1  JR source register is $31
- redirect_ready  in  1  fetch accepts the redirect this cycle
- redirect_valid  out  1  redirect request pending
- redirect_pc  out  XLEN  target PC of the pending redirect
- redirect_misalign  out  1  pending JR target had nonzero bits [1:0]
- ex_stall  out  1  EX must hold its instruction
- link_addr  out  XLEN  combinational link value = ex_pc_plus4 (for JAL write-back of $31)
- ras_pred_valid  out  1  RAS non-empty
- ras_pred_pc  out  XLEN  RAS top entry
- redirect_count  out  CNT_W  number of redirects accepted by fetch

## Operation
- Capture condition: cap = ex_valid & (ex_jump_mode != 00) & (!redirect_valid | redirect_ready).
- Target:
  - J/JAL: {ex_pc_plus4[XLEN-1:28], ex_instr[25:0], 2'b00}.
  - JR: {ex_rs_data[XLEN-1:2], 2'b00}. redirect_misalign <= |ex_rs_data[1:0]. J/JAL capture clears misalign.
- On cap: redirect_pc <= target, redirect_valid <= 1.
- Else if redirect_valid & redirect_ready: redirect_valid <= 0. redirect_pc and misalign hold their value.
- Handshake: the request is transferred on a cycle with redirect_valid & redirect_ready. redirect_pc is stable while valid & !ready. The request is never dropped except by reset.
- ex_stall = ex_valid & (ex_jump_mode != 00) & redirect_valid & !redirect_ready (combinational). Non-jump instructions never stall.
- redirect_count increments by 1 on each transfer and wraps modulo 2^CNT_W.
- RAS: circular buffer, top pointer tp (log2 RAS_DEPTH bits), occupancy cnt (0..RAS_DEPTH).
  - Push on cap & JAL: write ex_pc_plus4 at tp+1, tp <= tp+1, cnt <= min(cnt+1, RAS_DEPTH). On overflow the oldest entry is silently overwritten.
  - Pop on cap & JR & ex_rs_is_ra & cnt != 0: tp <= tp-1, cnt <= cnt-1.
  - Pop on empty: no state change.
  - JR from a register other than $31 does not touch the RAS.
  - Push and pop are mutually exclusive (one instruction per cycle).
- ras_pred_valid = (cnt != 0). ras_pred_pc = entry[tp] when valid, else 0.

## Timing
- Reset (async): redirect_valid=0, redirect_pc=0, redirect_misalign=0, redirect_count=0, tp=0, cnt=0, RAS entries=0. Therefore ras_pred_valid=0, ras_pred_pc=0, ex_stall=0.
- Latency: a target captured at edge N is visible on redirect_pc/redirect_valid after edge N. The RAS reflects a push/pop after the same edge.
- Back-to-back: if a redirect transfers in the same cycle a new jump is presented, the new jump is captured, and redirect_valid stays 1 with the new target.
- Reset asserted mid-request clears the pending redirect immediately, without waiting for a clock edge. After reset deasserts, operation resumes at the next edge.
- link_addr and ex_stall are combinational with zero latency. All other outputs are registered.

## Test plan
- J capture: ex_pc_plus4=0x0040_0004, instr[25:0]=0x0100000, mode=01, ready=1 -> next cycle redirect_valid=1, redirect_pc=0x0040_0000. After the transfer, redirect_count=1.
- JR misaligned: ex_rs_data=0x1000_0006, mode=10 -> redirect_pc=0x1000_0004, redirect_misalign=1. A following J clears misalign.
- Backpressure: hold redirect_ready=0 for 3 cycles with a second JR at 0x2000_0000 presented -> ex_stall=1 for those cycles, redirect_pc stays at the first target. When ready=1, the second target is captured the next cycle. redirect_count advances by exactly 1 per transfer.
- RAS overflow/underflow (RAS_DEPTH=4): 5 JALs with pc_plus4 = 0x10, 0x20, 0x30, 0x40, 0x50, then 5 JR $ra.
  - After the pushes: ras_pred_pc=0x50.
  - Successive pops expose 0x40, 0x30, 0x20, then ras_pred_valid=0 (0x10 was lost).
  - The 5th pop leaves the RAS empty and unchanged.
- JR non-$31: ex_rs_is_ra=0 with the RAS holding 2 entries -> cnt and ras_pred_pc unchanged, redirect issued to ex_rs_data.
- Async reset mid-operation: assert rst between edges while redirect_valid=1 and cnt=3 -> redirect_valid, cnt, redirect_count become 0 before the next edge, and ras_pred_valid=0.

Source files
------------

// File: rtl/jump_redirect_unit.sv
// EX-stage jump resolution: registered redirect request to fetch with valid/ready handshake,
// plus a small circular return-address stack giving fetch an early return prediction.
module jump_redirect_unit #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       ex_jump_mode,
  input  logic [XLEN-1:0]  ex_pc_plus4,
  input  logic [31:0]      ex_instr,
  input  logic [XLEN-1:0]  ex_rs_data,
  input  logic             ex_rs_is_ra,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             redirect_misalign,
  output logic             ex_stall,
  output logic [XLEN-1:0]  link_addr,
  output logic             ras_pred_valid,
  output logic [XLEN-1:0]  ras_pred_pc,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int OCC_W = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_JR   = 2'b10;
  localparam logic [1:0] MODE_JAL  = 2'b11;

  logic             redirect_valid_reg;
  logic [XLEN-1:0]  redirect_pc_reg;
  logic             misalign_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] tp_reg, tp_next, tp_inc;
  logic [OCC_W-1:0] cnt_reg, cnt_next;
  logic [XLEN-1:0]  ras_entry [RAS_DEPTH];

  logic            is_jump, cap, xfer, push, pop;
  logic [XLEN-1:0] target_next;
  logic            misalign_next;
  logic            unused_instr_bits;

  assign unused_instr_bits = &{1'b0, ex_instr[31:26]};

  assign is_jump = ex_valid & (ex_jump_mode != MODE_NONE);
  assign cap     = is_jump & (!redirect_valid_reg | redirect_ready);
  assign xfer    = redirect_valid_reg & redirect_ready;
  assign push    = cap & (ex_jump_mode == MODE_JAL);
  assign pop     = cap & (ex_jump_mode == MODE_JR) & ex_rs_is_ra & (cnt_reg != '0);
  assign tp_inc  = tp_reg + 1'b1;

  always_comb begin
    target_next   = {ex_pc_plus4[XLEN-1:28], ex_instr[25:0], 2'b00};
    misalign_next = 1'b0;
    if (ex_jump_mode == MODE_JR) begin
      target_next   = {ex_rs_data[XLEN-1:2], 2'b00};
      misalign_next = |ex_rs_data[1:0];
    end
  end

  // Occupancy saturates at RAS_DEPTH; the pointer keeps wrapping so the oldest entry is overwritten.
  always_comb begin
    tp_next  = tp_reg;
    cnt_next = cnt_reg;
    if (push) begin
      tp_next = tp_inc;
      if (cnt_reg != OCC_W'(RAS_DEPTH))
        cnt_next = cnt_reg + 1'b1;
    end else if (pop) begin
      tp_next  = tp_reg - 1'b1;
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      misalign_reg       <= 1'b0;
      count_reg          <= '0;
      tp_reg             <= '0;
      cnt_reg            <= '0;
    end else begin
      if (cap) begin
        redirect_valid_reg <= 1'b1;
        redirect_pc_reg    <= target_next;
        misalign_reg       <= misalign_next;
      end else if (xfer) begin
        redirect_valid_reg <= 1'b0;
      end
      if (xfer)
        count_reg <= count_reg + 1'b1;
      tp_reg  <= tp_next;
      cnt_reg <= cnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
      logic [XLEN-1:0] entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          entry_reg <= '0;
        else if (push && (tp_inc == PTR_W'(gi)))
          entry_reg <= ex_pc_plus4;
      end
      assign ras_entry[gi] = entry_reg;
    end
  endgenerate

  assign redirect_valid    = redirect_valid_reg;
  assign redirect_pc       = redirect_pc_reg;
  assign redirect_misalign = misalign_reg;
  assign redirect_count    = count_reg;
  assign ex_stall          = is_jump & redirect_valid_reg & !redirect_ready;
  assign link_addr         = ex_pc_plus4;
  assign ras_pred_valid    = (cnt_reg != '0);
  assign ras_pred_pc       = (cnt_reg != '0) ? ras_entry[tp_reg] : '0;

endmodule

// File: tb/tb_jump_redirect_unit.sv
// Directed bench for jump_redirect_unit: capture, misalign, backpressure, RAS wrap, async reset.
module tb_jump_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  ex_jump_mode;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_instr;
  logic [31:0] ex_rs_data;
  logic        ex_rs_is_ra;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_misalign;
  logic        ex_stall;
  logic [31:0] link_addr;
  logic        ras_pred_valid;
  logic [31:0] ras_pred_pc;
  logic [15:0] redirect_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jump_redirect_unit #(.XLEN(32), .RAS_DEPTH(4), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_jump_mode     (ex_jump_mode),
    .ex_pc_plus4      (ex_pc_plus4),
    .ex_instr         (ex_instr),
    .ex_rs_data       (ex_rs_data),
    .ex_rs_is_ra      (ex_rs_is_ra),
    .redirect_ready   (redirect_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_misalign(redirect_misalign),
    .ex_stall         (ex_stall),
    .link_addr        (link_addr),
    .ras_pred_valid   (ras_pred_valid),
    .ras_pred_pc      (ras_pred_pc),
    .redirect_count   (redirect_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Present one EX instruction; called just after a falling edge.
  task automatic drive(input logic [1:0] mode, input logic [31:0] pc4, input logic [31:0] instr,
                       input logic [31:0] rs, input logic is_ra);
    ex_valid     = (mode != 2'b00);
    ex_jump_mode = mode;
    ex_pc_plus4  = pc4;
    ex_instr     = instr;
    ex_rs_data   = rs;
    ex_rs_is_ra  = is_ra;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic next_slot;
    @(negedge clk);
  endtask

  logic [31:0] jal_pc [5];
  logic [31:0] pop_exp [5];

  initial begin
    jal_pc  = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    pop_exp = '{32'h40, 32'h30, 32'h20, 32'h0, 32'h0};
    rst = 1'b1;
    redirect_ready = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    #12;
    check_eq("reset_valid", redirect_valid, 0);
    check_eq("reset_pc", redirect_pc, 0);
    check_eq("reset_misalign", redirect_misalign, 0);
    check_eq("reset_count", redirect_count, 0);
    check_eq("reset_ras_valid", ras_pred_valid, 0);
    check_eq("reset_stall", ex_stall, 0);
    next_slot();
    rst = 1'b0;

    // J capture
    next_slot();
    drive(2'b01, 32'h0040_0004, 32'h0010_0000, 32'h0, 1'b0);
    #1 check_eq("link_addr", link_addr, 32'h0040_0004);
    step();
    check_eq("j_valid", redirect_valid, 1);
    check_eq("j_pc", redirect_pc, 32'h0040_0000);
    check_eq("j_count_pre", redirect_count, 0);
    next_slot();
    drive(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    check_eq("j_valid_after", redirect_valid, 0);
    check_eq("j_count", redirect_count, 1);

    // JR misaligned, then J clears misalign
    next_slot();
    drive(2'b10, 32'h0, 32'h0, 32'h1000_0006, 1'b0);
    step();
    check_eq("jr_pc", redirect_pc, 32'h1000_0004);
    check_eq("jr_misalign", redirect_misalign, 1);
    next_slot();
    drive(2'b01, 32'h0040_0004, 32'h0010_0000, 32'h0, 1'b0);
    step();
    check_eq("j_clear_misalign", redirect_misalign, 0);
    check_eq("j2_pc", redirect_pc, 32'h0040_0000);
    check_eq("j2_count", redirect_count, 2);
    next_slot();
    drive(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    check_eq("idle_count", redirect_count, 3);

    // Backpressure
    next_slot();
    drive(2'b10, 32'h0, 32'h0, 32'h1000_0000, 1'b0);
    step();
    check_eq("bp_first_pc", redirect_pc, 32'h1000_0000);
    for (int i = 0; i < 3; i++) begin
      next_slot();
      redirect_ready = 1'b0;
      drive(2'b10, 32'h0, 32'h0, 32'h2000_0000, 1'b0);
      #1 check_eq($sformatf("bp_stall_%0d", i), ex_stall, 1);
      step();
      check_eq($sformatf("bp_hold_pc_%0d", i), redirect_pc, 32'h1000_0000);
      check_eq($sformatf("bp_hold_valid_%0d", i), redirect_valid, 1);
      check_eq($sformatf("bp_hold_count_%0d", i), redirect_count, 3);
    end
    next_slot();
    redirect_ready = 1'b1;
    #1 check_eq("bp_stall_release", ex_stall, 0);
    step();
    check_eq("bp_second_pc", redirect_pc, 32'h2000_0000);
    check_eq("bp_second_valid", redirect_valid, 1);
    check_eq("bp_count_4", redirect_count, 4);
    next_slot();
    drive(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    check_eq("bp_count_5", redirect_count, 5);

    // RAS overflow then underflow
    for (int i = 0; i < 5; i++) begin
      next_slot();
      drive(2'b11, jal_pc[i], 32'h0, 32'h0, 1'b0);
      step();
    end
    check_eq("ras_top_after_push", ras_pred_pc, 32'h50);
    check_eq("ras_valid_after_push", ras_pred_valid, 1);
    for (int i = 0; i < 5; i++) begin
      next_slot();
      drive(2'b10, 32'h0, 32'h0, 32'h50, 1'b1);
      step();
      check_eq($sformatf("ras_pop_pc_%0d", i), ras_pred_pc, pop_exp[i]);
      check_eq($sformatf("ras_pop_valid_%0d", i), ras_pred_valid, (i < 3) ? 1 : 0);
    end
    next_slot();
    drive(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    check_eq("ras_count_15", redirect_count, 15);

    // JR through a non-$31 register leaves the RAS alone
    next_slot();
    drive(2'b11, 32'hA0, 32'h0, 32'h0, 1'b0);
    step();
    next_slot();
    drive(2'b11, 32'hB0, 32'h0, 32'h0, 1'b0);
    step();
    check_eq("ras2_top", ras_pred_pc, 32'hB0);
    next_slot();
    drive(2'b10, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
    step();
    check_eq("jr_other_pc", redirect_pc, 32'h1234_5678);
    check_eq("jr_other_ras_pc", ras_pred_pc, 32'hB0);
    check_eq("jr_other_ras_valid", ras_pred_valid, 1);
    next_slot();
    drive(2'b10, 32'h0, 32'h0, 32'hB0, 1'b1);
    step();
    check_eq("jr_ra_pop", ras_pred_pc, 32'hA0);
    next_slot();
    drive(2'b11, 32'hC0, 32'h0, 32'h0, 1'b0);
    step();
    next_slot();
    drive(2'b11, 32'hD0, 32'h0, 32'h0, 1'b0);
    step();
    check_eq("pre_rst_top", ras_pred_pc, 32'hD0);
    check_eq("pre_rst_valid", redirect_valid, 1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", redirect_valid, 0);
    check_eq("arst_pc", redirect_pc, 0);
    check_eq("arst_count", redirect_count, 0);
    check_eq("arst_ras_valid", ras_pred_valid, 0);
    check_eq("arst_ras_pc", ras_pred_pc, 0);
    next_slot();
    drive(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    next_slot();
    drive(2'b01, 32'h3000_0004, 32'h0000_0040, 32'h0, 1'b0);
    step();
    check_eq("resume_pc", redirect_pc, 32'h3000_0100);
    check_eq("resume_valid", redirect_valid, 1);
    next_slot();
    drive(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    check_eq("resume_count", redirect_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
